// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake for uart_tx_arbiter.
// Lane i occupies req_byte[8i+7:8i]. Requesters drive through the master
// modport; the arbiter answers through the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_byte, output req_last, input req_ready);
    modport slave  (input req_valid, input req_byte, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one simple_uart transmitter among NUM_REQ (2..4)
// byte sources. One byte is accepted per grant, strobed into the UART for a
// single cycle, and held on uart_tx_byte until the next acceptance.
// Optional feature: define UART_ARB_LOCK_EN to keep multi-byte messages
// contiguous; the arbiter then stays on a lane until it sends req_last=1.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clock_12mhz,
    input  logic               reset,
    uart_tx_arbiter_if.slave   req,
    output logic               uart_transmit,
    output logic [7:0]         uart_tx_byte,
    input  logic               uart_is_transmitting,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               start_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         to_cnt_q, to_cnt_d;
    logic [7:0]         byte_q, byte_d;
    logic               transmit_q, transmit_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] ready;
    logic               found;
    logic [1:0]         winner;
    logic [7:0]         sel_byte;
    logic               sel_last;
    logic               accept;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;

    // While locked, only the lane that owns the message (ptr) may win
    always_comb begin
        eligible = req.req_valid;
        if (lock_q) eligible = req.req_valid & (NUM_REQ'(1) << ptr_q);
    end
`else
    logic unused_last;
    assign unused_last = ^req.req_last;
    assign eligible    = req.req_valid;
`endif

    // Pick the eligible lane closest after ptr (distance 0 means ptr+1)
    always_comb begin
        int best_d;
        int d;
        found    = 1'b0;
        winner   = ptr_q;
        best_d   = NUM_REQ;
        sel_byte = 8'h00;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(ptr_q) - 1;
            if (d < 0) d = d + NUM_REQ;
            if (eligible[i] && d < best_d) begin
                best_d = d;
                winner = 2'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 2'(i)) begin
                sel_byte = req.req_byte[8*i +: 8];
                sel_last = req.req_last[i];
            end
        end
    end

    // One-hot ready for the winner, only in IDLE and never while in reset
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            ready[i] = found && (state_q == IDLE) && !reset && (winner == 2'(i));
    end

    assign req.req_ready = ready;
    assign accept        = |ready;

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        to_cnt_d   = to_cnt_q;
        byte_d     = byte_q;
        transmit_d = 1'b0;
        timeout_d  = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    byte_d     = sel_byte;
                    grant_d    = winner;
                    ptr_d      = winner;
                    transmit_d = 1'b1;
                    state_d    = ISSUE;
`ifdef UART_ARB_LOCK_EN
                    lock_d     = !sel_last;
`endif
                end
            end
            ISSUE: begin
                to_cnt_d = 2'd0;
                state_d  = WAIT_START;
            end
            WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == 2'd3) begin
                    // UART never picked up the strobe: drop the byte
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM and registered outputs
    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 2'(NUM_REQ - 1);
            grant_q    <= 2'd0;
            to_cnt_q   <= 2'd0;
            byte_q     <= 8'h00;
            transmit_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            to_cnt_q   <= to_cnt_d;
            byte_q     <= byte_d;
            transmit_q <= transmit_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign uart_transmit = transmit_q;
    assign uart_tx_byte  = byte_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign start_timeout = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: random requesters and a UART
// behaviour model, checked every cycle against a timeline-level reference.
module tb_uart_tx_arbiter;
    localparam int N = 3;

    logic       clock_12mhz = 1'b0;
    logic       reset = 1'b1;
    logic       uart_is_transmitting = 1'b0;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic [1:0] grant_id;
    logic       busy;
    logic       start_timeout;

    uart_tx_arbiter_if #(.NUM_REQ(N)) rif ();

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clock_12mhz          (clock_12mhz),
        .reset                (reset),
        .req                  (rif),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .grant_id             (grant_id),
        .busy                 (busy),
        .start_timeout        (start_timeout)
    );

    always #5 clock_12mhz = ~clock_12mhz;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @step %0d: got %0h expected %0h", tag, step, got, exp);
        end
    endtask

    // reference model: step indices of the transaction timeline
    int         step = 0;
    int         m_ptr = N - 1;
    bit         m_lock = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_grant = 0;
    int         strobe_at = -100;
    int         frame_end = -100;
    int         idle_at = 0;
    int         timeout_at = -100;

    logic [N-1:0] v = '0;
    logic [N-1:0] last = '0;
    logic [7:0]   b [N];

    // mode 0: lanes 0/1 always valid with 41/42, 20-cycle frames
    // mode 1: random lanes, random frames, occasional missing start, resets
    task automatic do_step(input int mode);
        int  win;
        int  lane;
        bit  rst;
        int  f;
        @(negedge clock_12mhz);
        chk("uart_transmit", {31'd0, uart_transmit}, {31'd0, step == strobe_at});
        chk("busy", {31'd0, busy}, {31'd0, (step >= strobe_at) && (step < idle_at)});
        chk("start_timeout", {31'd0, start_timeout}, {31'd0, step == timeout_at});
        chk("uart_tx_byte", {24'd0, uart_tx_byte}, {24'd0, m_byte});
        chk("grant_id", {30'd0, grant_id}, 32'(m_grant));

        rst = (mode == 1) && (step > strobe_at + 1) && (step < idle_at - 1) &&
              ($urandom_range(0, 29) == 0);
        reset = rst;
        uart_is_transmitting = (step > strobe_at) && (step <= frame_end);
        for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
                v[i] = (i < 2);
                b[i] = 8'h41 + 8'(i);
                last[i] = 1'b1;
            end else if (!v[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    v[i] = 1'b1;
                    b[i] = 8'($urandom);
                    last[i] = ($urandom_range(0, 2) != 0);
                end
            end else if ($urandom_range(0, 39) == 0) begin
                v[i] = 1'b0;
            end
            rif.req_byte[8*i +: 8] = b[i];
        end
        rif.req_valid = v;
        rif.req_last = last;
        #1;

        win = -1;
        if (!rst && step >= idle_at) begin
            for (int k = 1; k <= N; k++) begin
                lane = (m_ptr + k) % N;
`ifdef UART_ARB_LOCK_EN
                if (m_lock && lane != m_ptr) continue;
`endif
                if (win < 0 && v[lane]) win = lane;
            end
        end
        chk("req_ready", 32'(rif.req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);

        if (rst) begin
            m_ptr = N - 1; m_lock = 1'b0; m_byte = 8'h00; m_grant = 0;
            strobe_at = -100; frame_end = -100; timeout_at = -100;
            idle_at = step + 1;
        end else if (win >= 0) begin
            m_byte = b[win]; m_grant = win; m_ptr = win; m_lock = !last[win];
            v[win] = 1'b0;
            strobe_at = step + 1;
            if (mode == 1 && $urandom_range(0, 5) == 0) begin
                frame_end = -100;
                timeout_at = strobe_at + 5;
                idle_at = strobe_at + 5;
            end else begin
                f = (mode == 0) ? 20 : $urandom_range(1, 6);
                frame_end = strobe_at + f;
                idle_at = strobe_at + f + 2;
            end
        end
        step++;
    endtask

    initial begin
        rif.req_valid = '0;
        rif.req_last  = '0;
        rif.req_byte  = '0;
        for (int i = 0; i < N; i++) b[i] = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clock_12mhz);
        reset = 1'b0;
        for (int s = 0; s < 200; s++) do_step(0);
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        for (int s = 0; s < 4000; s++) do_step(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
